// File: rtl/sparsity_flag_encoder_if.sv
// Handshake and result bundle between the sparsity flag encoder and its environment.
// The encoder takes the master view; the producer/consumer side takes the slave view.
interface sparsity_flag_encoder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  start;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  flag_wr_req;
  logic [ADDR_WIDTH-1:0] flag_wr_addr;
  logic                  flag_wr_data;
  logic                  nz_valid;
  logic                  nz_ready;
  logic [DATA_WIDTH-1:0] nz_data;
  logic                  done;
  logic [ADDR_WIDTH:0]   nz_count;
  logic                  overflow;

  modport master (
    input  start, in_valid, in_data, in_last, nz_ready,
    output in_ready, flag_wr_req, flag_wr_addr, flag_wr_data,
           nz_valid, nz_data, done, nz_count, overflow
  );

  modport slave (
    output start, in_valid, in_data, in_last, nz_ready,
    input  in_ready, flag_wr_req, flag_wr_addr, flag_wr_data,
           nz_valid, nz_data, done, nz_count, overflow
  );
endinterface

// File: rtl/sparsity_flag_encoder.sv
// Writes one zero/non-zero flag per dense element and forwards only the non-zero elements
// through a 2-entry FIFO; reports the non-zero count and truncation at end of frame.
module sparsity_flag_encoder #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clk_en,
  sparsity_flag_encoder_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  localparam logic [ADDR_WIDTH-1:0] IDX_MAX = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH:0]   nz_count_q, nz_count_d;
  logic                  overflow_q, overflow_d;
  logic                  flag_req_q, flag_req_d;
  logic [ADDR_WIDTH-1:0] flag_addr_q, flag_addr_d;
  logic                  flag_data_q, flag_data_d;
  logic [DATA_WIDTH-1:0] mem_q [2];
  logic [DATA_WIDTH-1:0] mem_d [2];
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            occ_q, occ_d;

  logic in_ready_c, done_c, nz_valid_c;
  logic accept, push, pop, elem_nz, frame_end, start_frame;

  assign elem_nz     = |bus.in_data;
  assign accept      = bus.in_valid & in_ready_c;
  assign push        = accept & elem_nz;
  assign nz_valid_c  = (occ_q != 2'd0);
  assign pop         = nz_valid_c & bus.nz_ready & clk_en;
  assign frame_end   = bus.in_last | (idx_q == IDX_MAX);
  assign start_frame = (state_q == S_IDLE) & bus.start;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else if (clk_en) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (accept && frame_end) state_d = S_DRAIN;
      S_DRAIN: if (occ_q == 2'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and strobes are gated by clk_en so a frozen block presents nothing new
  always_comb begin
    in_ready_c = clk_en && (state_q == S_RUN) && (occ_q < 2'd2);
    done_c     = clk_en && (state_q == S_DONE);
  end

  always_comb begin
    idx_d       = idx_q;
    nz_count_d  = nz_count_q;
    overflow_d  = overflow_q;
    flag_req_d  = accept;
    flag_addr_d = flag_addr_q;
    flag_data_d = flag_data_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    if (start_frame) begin
      idx_d      = '0;
      nz_count_d = '0;
      overflow_d = 1'b0;
    end
    if (accept) begin
      flag_addr_d = idx_q;
      flag_data_d = elem_nz;
      idx_d       = idx_q + ADDR_WIDTH'(1);
      if ((idx_q == IDX_MAX) && !bus.in_last) overflow_d = 1'b1;
    end
    if (push) begin
      mem_d[wr_ptr_q] = bus.in_data;
      wr_ptr_d        = ~wr_ptr_q;
      nz_count_d      = nz_count_q + (ADDR_WIDTH+1)'(1);
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      nz_count_q  <= '0;
      overflow_q  <= 1'b0;
      flag_req_q  <= 1'b0;
      flag_addr_q <= '0;
      flag_data_q <= 1'b0;
      mem_q[0]    <= '0;
      mem_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= 2'd0;
    end else if (clk_en) begin
      idx_q       <= idx_d;
      nz_count_q  <= nz_count_d;
      overflow_q  <= overflow_d;
      flag_req_q  <= flag_req_d;
      flag_addr_q <= flag_addr_d;
      flag_data_q <= flag_data_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.flag_wr_req  = flag_req_q & clk_en;
  assign bus.flag_wr_addr = flag_addr_q;
  assign bus.flag_wr_data = flag_data_q;
  assign bus.nz_valid     = nz_valid_c;
  assign bus.nz_data      = mem_q[rd_ptr_q];
  assign bus.done         = done_c;
  assign bus.nz_count     = nz_count_q;
  assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_sparsity_flag_encoder.sv
// Directed bench: stimulus pushes hand-computed flag writes, compacted data and end-of-frame
// results into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_sparsity_flag_encoder;
  localparam int DW = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;
  bit   gate_en = 1'b0;

  sparsity_flag_encoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sparsity_flag_encoder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  int acc_cnt = 0;

  int exp_addr[$];
  bit exp_fdat[$];
  int exp_nz[$];
  int exp_cnt[$];
  bit exp_ovf[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_flag(input int a, input bit d);
    exp_addr.push_back(a);
    exp_fdat.push_back(d);
  endtask

  task automatic exp_done(input int c, input bit o);
    exp_cnt.push_back(c);
    exp_ovf.push_back(o);
  endtask

  // Monitor: compares every flag write, every popped element and every done pulse
  initial begin
    forever begin
      @(negedge clk);
      if (bus.flag_wr_req === 1'b1) begin
        if (exp_addr.size() == 0) chk("flag_unexpected", 1, 0);
        else begin
          chk("flag_addr", 32'(bus.flag_wr_addr), 32'(exp_addr.pop_front()));
          chk("flag_data", 32'(bus.flag_wr_data), 32'(exp_fdat.pop_front()));
        end
      end
      if (bus.nz_valid === 1'b1 && bus.nz_ready && clk_en) begin
        if (exp_nz.size() == 0) chk("nz_unexpected", 32'(bus.nz_data), 32'hFFFF);
        else chk("nz_data", 32'(bus.nz_data), 32'(exp_nz.pop_front()));
      end
      if (bus.done === 1'b1) begin
        if (exp_cnt.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          chk("nz_count", 32'(bus.nz_count), 32'(exp_cnt.pop_front()));
          chk("overflow", 32'(bus.overflow), 32'(exp_ovf.pop_front()));
          chk("done_after_drain", 32'(exp_nz.size()), 0);
          chk("done_nz_valid", 32'(bus.nz_valid), 0);
        end
        done_cnt++;
      end
    end
  end

  // clk_en toggler for the gated frame
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (gate_en) clk_en = ~clk_en;
      else clk_en = 1'b1;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge or after the bound
  task automatic send_elem(input logic [DW-1:0] d, input logic l, input int bound, output bit ok);
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    for (int c = 0; c < bound && !ok; c++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    if (ok) acc_cnt++;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l);
    bit ok;
    send_elem(d, l, 100, ok);
    chk("accept", 32'(ok), 1);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int c = 0; c < 200 && done_cnt < target; c++) @(posedge clk);
    #1;
    chk("done_seen", 32'(done_cnt), 32'(target));
  endtask

  initial begin
    bit ok;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.nz_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_flag_wr_req", 32'(bus.flag_wr_req), 0);
    chk("rst_flag_wr_addr", 32'(bus.flag_wr_addr), 0);
    chk("rst_nz_valid", 32'(bus.nz_valid), 0);
    chk("rst_nz_data", 32'(bus.nz_data), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_nz_count", 32'(bus.nz_count), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Mixed frame
    exp_flag(0, 1); exp_flag(1, 0); exp_flag(2, 0); exp_flag(3, 1);
    exp_nz.push_back(8'h05); exp_nz.push_back(8'h7F); exp_done(2, 0);
    pulse_start();
    send(8'h05, 0); send(8'h00, 0); send(8'h00, 0); send(8'h7F, 1);
    wait_done(1);

    // All-zero frame of 8; last coincides with the final address, so no overflow
    for (int i = 0; i < 8; i++) exp_flag(i, 0);
    exp_done(0, 0);
    pulse_start();
    for (int i = 0; i < 8; i++) send(8'h00, (i == 7));
    wait_done(2);

    // Backpressure: third element must wait until the FIFO frees a slot
    bus.nz_ready = 1'b0;
    acc_cnt = 0;
    exp_flag(0, 1); exp_flag(1, 1); exp_flag(2, 1);
    exp_nz.push_back(8'h11); exp_nz.push_back(8'h22); exp_nz.push_back(8'h33); exp_done(3, 0);
    pulse_start();
    fork
      begin send(8'h11, 0); send(8'h22, 0); send(8'h33, 1); end
    join_none
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("bp_accepted", 32'(acc_cnt), 2);
    chk("bp_in_ready", 32'(bus.in_ready), 0);
    chk("bp_nz_valid", 32'(bus.nz_valid), 1);
    chk("bp_nz_data_held", 32'(bus.nz_data), 32'h11);
    @(posedge clk); #1;
    bus.nz_ready = 1'b1;
    wait_done(3);

    // Forced end at 8 elements without last
    for (int i = 0; i < 8; i++) begin exp_flag(i, 1); exp_nz.push_back(i + 1); end
    exp_done(8, 1);
    pulse_start();
    for (int i = 0; i < 8; i++) send(8'(i + 1), 0);
    send_elem(8'h09, 0, 12, ok);
    chk("ovf_9th_rejected", 32'(ok), 0);
    wait_done(4);
    chk("ovf_sticky", 32'(bus.overflow), 1);
    chk("ovf_count_held", 32'(bus.nz_count), 8);
    pulse_start();
    chk("start_clears_ovf", 32'(bus.overflow), 0);
    chk("start_clears_count", 32'(bus.nz_count), 0);
    exp_flag(0, 0); exp_done(0, 0);
    send(8'h00, 1);
    wait_done(5);

    // Same mixed frame with clk_en toggling every cycle
    exp_flag(0, 1); exp_flag(1, 0); exp_flag(2, 0); exp_flag(3, 1);
    exp_nz.push_back(8'h05); exp_nz.push_back(8'h7F); exp_done(2, 0);
    pulse_start();
    gate_en = 1'b1;
    send(8'h05, 0); send(8'h00, 0); send(8'h00, 0); send(8'h7F, 1);
    wait_done(6);
    gate_en = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset mid-frame, then a fresh frame restarts at address 0
    bus.nz_ready = 1'b0;
    exp_flag(0, 1); exp_flag(1, 1);
    pulse_start();
    send(8'h40, 0); send(8'h41, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("midrst_nz_valid", 32'(bus.nz_valid), 0);
    chk("midrst_nz_count", 32'(bus.nz_count), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 0);
    rst = 1'b0;
    bus.nz_ready = 1'b1;
    @(posedge clk); #1;
    exp_flag(0, 0); exp_flag(1, 1); exp_nz.push_back(8'h09); exp_done(1, 0);
    pulse_start();
    send(8'h00, 0); send(8'h09, 1);
    wait_done(7);
    repeat (3) @(posedge clk); #1;

    chk("flag_queue_drained", 32'(exp_addr.size()), 0);
    chk("nz_queue_drained", 32'(exp_nz.size()), 0);
    chk("done_queue_drained", 32'(exp_cnt.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
